// File: rtl/scroll_banner_gen_if.sv
// scroll_banner_gen_if: message RAM write port.
// The host drives slot writes; the banner consumes them.
interface scroll_banner_gen_if #(
  parameter int MSG_LEN = 32
);
  localparam int AW = $clog2(MSG_LEN);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;

  modport master (
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/scroll_banner_gen.sv
// scroll_banner_gen: scrolling text band on a VGA raster.
// Message RAM -> external font ROM -> colour, 3-cycle pipeline.
module scroll_banner_gen #(
  parameter int         MSG_LEN = 32,
  parameter int         V_RES   = 480,
  parameter int         TOP_ROW = 224,
  parameter logic [2:0] FG      = 3'b111,
  parameter logic [2:0] BG      = 3'b001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         pixel_x,
  input  logic [11:0]         pixel_y,
  input  logic                video_on,
  input  logic                hsync,
  input  logic                vsync,
  input  logic [1:0]          scale,
  input  logic [1:0]          speed,
  input  logic                dir,
  scroll_banner_gen_if.slave  wr,
  output logic [10:0]         font_addr,
  input  logic [7:0]          font_data,
  output logic [2:0]          rgb,
  output logic                video_on_out,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int OW = AW + 6;
  localparam logic [11:0] TICK_Y = 12'(V_RES);
  localparam logic [11:0] TOP_Y  = 12'(TOP_ROW);
  localparam logic [6:0]  SPACE  = 7'h20;

  typedef struct packed {
    logic [2:0] col;
    logic       band;
    logic       von;
    logic       hs;
    logic       vs;
  } stg_t;

  localparam stg_t STG_RST = '{
    col: 3'd0, band: 1'b0, von: 1'b0, hs: 1'b1, vs: 1'b1
  };

  // Codes are stored XOR 0x20, so the all-zero
  // power-up array reads back as spaces.
  logic [6:0]    mem [MSG_LEN];

  logic [1:0]    scale_q;
  logic [OW-1:0] offset;
  logic [OW-1:0] mask;
  logic [OW-1:0] step;
  logic          tick;

  logic [OW-1:0] vx;
  logic [11:0]   dy;
  logic [11:0]   band_end;
  logic [AW-1:0] ch;
  logic [2:0]    col;
  logic [3:0]    row;
  logic          in_band;

  stg_t          s1;
  stg_t          s2;
  logic [2:0]    rgb_d;

  // Frame-level terms: W-1 mask, tick, next scroll step.
  always_comb begin
    mask = {OW{1'b1}} >> (2'd3 - scale_q);
    tick = (pixel_x == '0) && (pixel_y == TICK_Y);
    if (dir)
      step = offset - OW'(speed);
    else
      step = offset + OW'(speed);
  end

  // Scale and offset move only on the frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset  <= '0;
      scale_q <= '0;
    end else if (tick) begin
      if (scale != scale_q) begin
        scale_q <= scale;
        offset  <= '0;
      end else begin
        offset  <= step & mask;
      end
    end
  end

  // Map the raster position into banner space.
  always_comb begin
    vx       = (OW'(pixel_x) + offset) & mask;
    dy       = pixel_y - TOP_Y;
    band_end = TOP_Y + (12'd16 << scale_q);
    ch       = AW'(vx >> (3 + scale_q));
    col      = 3'(vx >> scale_q);
    row      = 4'(dy >> scale_q);
    in_band  = (pixel_y >= TOP_Y) &&
               (pixel_y < band_end);
  end

  // Message RAM write port; no reset on contents.
  always_ff @(posedge clk) begin
    if (wr.wr_en)
      mem[wr.wr_addr] <= wr.wr_data ^ SPACE;
  end

  // Stage 1: read-first RAM lookup and pixel tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      font_addr <= '0;
      s1        <= STG_RST;
    end else begin
      font_addr <= {mem[ch] ^ SPACE, row};
      s1        <= '{
        col: col, band: in_band, von: video_on,
        hs: hsync, vs: vsync
      };
    end
  end

  // Stage 2: tags wait while the ROM fetches the row.
  always_ff @(posedge clk) begin
    if (rst)
      s2 <= STG_RST;
    else
      s2 <= s1;
  end

  // Colour pick: blanking, band, then glyph bit.
  always_comb begin
    rgb_d = 3'b000;
    if (!s2.von)
      rgb_d = 3'b000;
    else if (!s2.band)
      rgb_d = 3'b000;
    else if (font_data[3'd7 - s2.col])
      rgb_d = FG;
    else
      rgb_d = BG;
  end

  // Stage 3: registered colour and re-timed syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb          <= 3'b000;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
    end else begin
      rgb          <= rgb_d;
      video_on_out <= s2.von;
      hsync_out    <= s2.hs;
      vsync_out    <= s2.vs;
    end
  end

endmodule

// File: tb/tb_scroll_banner_gen.sv
// tb_scroll_banner_gen: directed checks of the banner.
// ROM model returns 8'h80 >> row, one lit column per row.
module tb_scroll_banner_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic [1:0]  scale;
  logic [1:0]  speed;
  logic        dir;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [2:0]  rgb;
  logic        video_on_out;
  logic        hsync_out;
  logic        vsync_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b001;

  scroll_banner_gen_if #(.MSG_LEN(32)) wr_if ();

  scroll_banner_gen #(
    .MSG_LEN(32), .V_RES(480), .TOP_ROW(224),
    .FG(FG), .BG(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .scale(scale), .speed(speed), .dir(dir),
    .wr(wr_if),
    .font_addr(font_addr), .font_data(font_data),
    .rgb(rgb), .video_on_out(video_on_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    font_data <= 8'h80 >> font_addr[2:0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pixel_x  = 12'd1;
    pixel_y  = 12'd0;
    video_on = 1'b0;
    hsync    = 1'b1;
    vsync    = 1'b1;
  endtask

  task automatic pix(input string tag,
                     input logic [11:0] x,
                     input logic [11:0] y,
                     input logic von,
                     input logic [10:0] exp_addr,
                     input logic [2:0] exp_rgb);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    step();
    check({tag, ".addr"}, 32'(font_addr), 32'(exp_addr));
    idle_in();
    step();
    step();
    check({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
  endtask

  task automatic ticks(input int n,
                       input logic [1:0] s,
                       input logic [1:0] sp,
                       input logic d);
    scale = s;
    speed = sp;
    dir   = d;
    for (int i = 0; i < n; i++) begin
      pixel_x  = 12'd0;
      pixel_y  = 12'd480;
      video_on = 1'b0;
      step();
      idle_in();
      step();
    end
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [6:0] d);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = a;
    wr_if.wr_data = d;
    step();
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic rst_pulse(input string tag);
    rst      = 1'b1;
    pixel_x  = 12'd0;
    pixel_y  = 12'd224;
    video_on = 1'b1;
    hsync    = 1'b0;
    vsync    = 1'b0;
    step();
    step();
    check({tag, ".rgb"}, 32'(rgb), 32'd0);
    check({tag, ".von"}, 32'(video_on_out), 32'd0);
    check({tag, ".hs"}, 32'(hsync_out), 32'd1);
    check({tag, ".vs"}, 32'(vsync_out), 32'd1);
    check({tag, ".fa"}, 32'(font_addr), 32'd0);
    rst = 1'b0;
    idle_in();
    step();
  endtask

  initial begin
    rst           = 1'b1;
    scale         = 2'd0;
    speed         = 2'd0;
    dir           = 1'b0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;
    idle_in();
    step();
    rst_pulse("reset");

    pix("init", 12'd0, 12'd224, 1'b1, 11'h200, FG);
    for (int i = 0; i < 32; i++)
      wr(5'(i), 7'(8'h41 + i));
    step();

    pix("st_a0",  12'd0, 12'd224, 1'b1, 11'h410, FG);
    pix("st_a1",  12'd1, 12'd224, 1'b1, 11'h410, BG);
    pix("st_b0",  12'd8, 12'd224, 1'b1, 11'h420, FG);
    pix("st_r1c0", 12'd0, 12'd225, 1'b1, 11'h411, BG);
    pix("st_r1c1", 12'd1, 12'd225, 1'b1, 11'h411, FG);
    pix("st_above", 12'd0, 12'd223, 1'b1, 11'h41F, 3'd0);
    pix("st_below", 12'd0, 12'd240, 1'b1, 11'h410, 3'd0);
    pix("st_last", 12'd0, 12'd239, 1'b1, 11'h41F, BG);
    pix("st_blank", 12'd0, 12'd224, 1'b0, 11'h410, 3'd0);

    pixel_x  = 12'd0;
    pixel_y  = 12'd224;
    video_on = 1'b1;
    hsync    = 1'b0;
    vsync    = 1'b0;
    step();
    idle_in();
    check("sync.d1", 32'(hsync_out), 32'd1);
    step();
    check("sync.d2", 32'(hsync_out), 32'd1);
    step();
    check("sync.hs3", 32'(hsync_out), 32'd0);
    check("sync.vs3", 32'(vsync_out), 32'd0);
    check("sync.von3", 32'(video_on_out), 32'd1);
    check("sync.rgb3", 32'(rgb), 32'(FG));
    step();
    check("sync.hs4", 32'(hsync_out), 32'd1);
    check("sync.von4", 32'(video_on_out), 32'd0);

    ticks(5, 2'd0, 2'd2, 1'b0);
    pix("lf_c2r0", 12'd0, 12'd224, 1'b1, 11'h420, BG);
    pix("lf_c2r2", 12'd0, 12'd226, 1'b1, 11'h422, FG);
    pix("lf_wrap", 12'd246, 12'd224, 1'b1, 11'h410, FG);
    ticks(1, 2'd0, 2'd0, 1'b0);
    pix("lf_frz", 12'd0, 12'd226, 1'b1, 11'h422, FG);

    ticks(5, 2'd0, 2'd2, 1'b1);
    pix("rt_zero0", 12'd0, 12'd226, 1'b1, 11'h412, BG);
    pix("rt_zero2", 12'd2, 12'd226, 1'b1, 11'h412, FG);
    ticks(1, 2'd0, 2'd1, 1'b1);
    pix("rt_255r0", 12'd0, 12'd224, 1'b1, 11'h600, BG);
    pix("rt_255r7", 12'd0, 12'd231, 1'b1, 11'h607, FG);
    pix("rt_255x1", 12'd1, 12'd224, 1'b1, 11'h410, FG);

    ticks(12, 2'd0, 2'd3, 1'b0);
    ticks(1, 2'd0, 2'd2, 1'b0);
    pix("o37_r0", 12'd0, 12'd224, 1'b1, 11'h450, BG);
    pix("o37_r5", 12'd0, 12'd229, 1'b1, 11'h455, FG);
    scale = 2'd2;
    pix("sc_hold", 12'd0, 12'd229, 1'b1, 11'h455, FG);
    ticks(1, 2'd2, 2'd3, 1'b0);
    pix("sc_x1", 12'd1, 12'd224, 1'b1, 11'h410, FG);
    pix("sc_x4", 12'd4, 12'd224, 1'b1, 11'h410, BG);
    pix("sc_x32", 12'd32, 12'd224, 1'b1, 11'h420, FG);
    pix("sc_r1", 12'd4, 12'd228, 1'b1, 11'h411, FG);
    pix("sc_y287", 12'd0, 12'd287, 1'b1, 11'h41F, BG);
    pix("sc_y288", 12'd0, 12'd288, 1'b1, 11'h410, 3'd0);
    ticks(1, 2'd2, 2'd1, 1'b1);
    pix("sc_w_r0", 12'd0, 12'd224, 1'b1, 11'h600, BG);
    pix("sc_w_r7", 12'd0, 12'd252, 1'b1, 11'h607, FG);
    ticks(1, 2'd0, 2'd0, 1'b0);
    pix("sc_back", 12'd0, 12'd224, 1'b1, 11'h410, FG);

    pixel_x       = 12'd0;
    pixel_y       = 12'd224;
    video_on      = 1'b1;
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = 5'd0;
    wr_if.wr_data = 7'h42;
    step();
    wr_if.wr_en = 1'b0;
    idle_in();
    check("coll.old", 32'(font_addr[10:4]), 32'h41);
    step();
    pix("coll.new", 12'd0, 12'd224, 1'b1, 11'h420, FG);

    wr(5'd0, 7'h41);
    ticks(1, 2'd0, 2'd2, 1'b0);
    pix("mr_pre", 12'd6, 12'd224, 1'b1, 11'h420, FG);
    rst_pulse("mid_rst");
    pix("mr_post", 12'd6, 12'd224, 1'b1, 11'h410, BG);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
